// File: rtl/pll_reset_seq.sv
// Reset sequencer for the 50->100 MHz PLL: pulses the PLL reset, qualifies lock, then releases system reset.
// Optional retry limit with a terminal FAIL state is enabled by defining PLL_RETRY_LIMIT_EN.
module pll_reset_seq #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 4,
   parameter int CNT_W         = 16
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       pll_ok,
   output logic [7:0] relock_cnt,
   output logic       fail
);

   localparam logic [CNT_W-1:0] RstLoad     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLoad  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

   // Reject parameter sets the shared down-counter cannot represent.
   if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1 ||
       RST_CYCLES > (1 << CNT_W) || LOCK_TIMEOUT > (1 << CNT_W) || STABLE_CYCLES > (1 << CNT_W)) begin : gBadParam
      $error("pll_reset_seq: illegal parameter combination");
   end

`ifdef PLL_RETRY_LIMIT_EN
   typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
   localparam int RetryW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
   localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRIES - 1);
   logic [RetryW-1:0] retry_q;
`else
   typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
`endif

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       lockSync_q;
   logic             lk;

   // locked is asynchronous to refclk; every decision uses the 2-FF synchronised copy.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lockSync_q <= 2'b00;
      end else begin
         lockSync_q <= {lockSync_q[0], locked};
      end
   end

   assign lk = lockSync_q[1];

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PLL_RST;
         cnt_q      <= RstLoad;
         pll_rst    <= 1'b1;
         sys_rst_n  <= 1'b0;
         pll_ok     <= 1'b0;
         relock_cnt <= 8'd0;
`ifdef PLL_RETRY_LIMIT_EN
         retry_q    <= '0;
         fail       <= 1'b0;
`endif
      end else begin
         case (state_q)
            PLL_RST: begin
               if (cnt_q == '0) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= TimeoutLoad;
                  pll_rst <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end

            // Lock seen in the timeout cycle wins over the retry.
            WAIT_LOCK: begin
               if (lk) begin
                  state_q <= STABLE;
                  cnt_q   <= StableLoad;
               end else if (cnt_q == '0) begin
`ifdef PLL_RETRY_LIMIT_EN
                  if (retry_q == RetryLast) begin
                     state_q <= FAIL;
                     pll_rst <= 1'b1;
                     fail    <= 1'b1;
                  end else begin
                     retry_q <= retry_q + RetryW'(1);
                     state_q <= PLL_RST;
                     cnt_q   <= RstLoad;
                     pll_rst <= 1'b1;
                  end
`else
                  state_q <= PLL_RST;
                  cnt_q   <= RstLoad;
                  pll_rst <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end

            STABLE: begin
               if (!lk) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= TimeoutLoad;
               end else if (cnt_q == '0) begin
                  state_q   <= RUN;
                  sys_rst_n <= 1'b1;
                  pll_ok    <= 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                  retry_q   <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end

            RUN: begin
               if (!lk) begin
                  state_q   <= PLL_RST;
                  cnt_q     <= RstLoad;
                  pll_rst   <= 1'b1;
                  sys_rst_n <= 1'b0;
                  pll_ok    <= 1'b0;
                  if (relock_cnt != 8'hFF) begin
                     relock_cnt <= relock_cnt + 8'd1;
                  end
               end
            end

`ifdef PLL_RETRY_LIMIT_EN
            FAIL: begin
               pll_rst   <= 1'b1;
               sys_rst_n <= 1'b0;
               pll_ok    <= 1'b0;
               fail      <= 1'b1;
            end
`endif

            default: begin
               state_q   <= PLL_RST;
               cnt_q     <= RstLoad;
               pll_rst   <= 1'b1;
               sys_rst_n <= 1'b0;
               pll_ok    <= 1'b0;
            end
         endcase
      end
   end

`ifndef PLL_RETRY_LIMIT_EN
   assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: a vector table for power-up/relock plus directed corner-case sequences.
// Build with PLL_RETRY_LIMIT_EN defined to exercise the retry-limit FAIL path.
module tb_pll_reset_seq;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       pll_ok;
   logic [7:0] relock_cnt;
   logic       fail;

   int cyc;
   int totalCnt;
   int passCnt;

   pll_reset_seq #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2),
      .CNT_W        (16)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .locked    (locked),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .pll_ok    (pll_ok),
      .relock_cnt(relock_cnt),
      .fail      (fail)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      int         cyc;
      logic       expPllRst;
      logic       expSysRstN;
      logic       expPllOk;
      logic [7:0] expRelock;
      logic       lockAfter;
   } vec_t;

   vec_t vecs[14];

   // Advance to cycle n, where cycle k is 2 time units after the k-th edge since reset release.
   task automatic stepTo(input int n);
      while (cyc < n) begin
         @(posedge refclk);
         #2;
         cyc++;
      end
   endtask

   task automatic applyStimulus(input logic lockVal);
      locked = lockVal;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(posedge refclk);
      #2;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic checkOutput(input string name, input logic ePllRst, input logic eSys,
                              input logic eOk, input logic [7:0] eRel, input logic eFail);
      totalCnt++;
      if (pll_rst === ePllRst && sys_rst_n === eSys && pll_ok === eOk &&
          relock_cnt === eRel && fail === eFail) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s cyc=%0d got pll_rst=%b sys_rst_n=%b pll_ok=%b relock=%0d fail=%b want %b %b %b %0d %b",
                  name, cyc, pll_rst, sys_rst_n, pll_ok, relock_cnt, fail,
                  ePllRst, eSys, eOk, eRel, eFail);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      totalCnt++;
      if (act === exp) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s cyc=%0d got %b want %b", name, cyc, act, exp);
      end
   endtask

   // Bounded wait on sys_rst_n; ok reports whether the level arrived within budget.
   task automatic waitSys(input logic val, input int budget, output logic ok);
      int n;
      n = 0;
      while (sys_rst_n !== val && n < budget) begin
         @(posedge refclk);
         #2;
         cyc++;
         n++;
      end
      ok = (sys_rst_n === val);
   endtask

   initial begin
      logic ok;
      totalCnt = 0;
      passCnt  = 0;
      cyc      = 0;
      locked   = 1'b0;
      rst_n    = 1'b0;

      // Power-up with lock at edge 10, then one lock loss in RUN and requalification.
      vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[1]  = '{3,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[2]  = '{4,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      vecs[3]  = '{9,  1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
      vecs[4]  = '{12, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
      vecs[5]  = '{19, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
      vecs[6]  = '{20, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1};
      vecs[7]  = '{25, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
      vecs[8]  = '{27, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
      vecs[9]  = '{28, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
      vecs[10] = '{31, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
      vecs[11] = '{32, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
      vecs[12] = '{40, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
      vecs[13] = '{41, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1};

      $display("[TB] power-up vector table");
      doReset();
      for (int i = 0; i < 14; i++) begin
         stepTo(vecs[i].cyc);
         checkOutput($sformatf("vec%0d", i), vecs[i].expPllRst, vecs[i].expSysRstN,
                     vecs[i].expPllOk, vecs[i].expRelock, 1'b0);
         applyStimulus(vecs[i].lockAfter);
      end

      // One-cycle lock glitch in STABLE forces a full requalification.
      $display("[TB] lock glitch during STABLE");
      applyStimulus(1'b0);
      doReset();
      stepTo(9);
      applyStimulus(1'b1);
      stepTo(16);
      checkOutput("glitchPre", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0);
      stepTo(17);
      applyStimulus(1'b1);
      stepTo(20);
      checkOutput("glitchHold", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      stepTo(27);
      checkOutput("glitchRequal", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      stepTo(28);
      checkOutput("glitchRelease", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);

      $display("[TB] lock timeout with locked held low");
      applyStimulus(1'b0);
      doReset();
`ifdef PLL_RETRY_LIMIT_EN
      stepTo(24);
      checkOutput("retry1Pulse", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      stepTo(28);
      checkOutput("retry1End", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      stepTo(47);
      checkOutput("retry2Before", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      stepTo(48);
      checkOutput("enterFail", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      stepTo(60);
      checkOutput("holdFail", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b1);
      stepTo(100);
      checkOutput("failIgnoresLock", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      doReset();
      checkOutput("failCleared", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0);
`else
      for (int k = 1; k <= 4; k++) begin
         stepTo(24 * k - 1);
         checkOutput($sformatf("toIdle%0d", k), 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
         stepTo(24 * k);
         checkOutput($sformatf("toPulse%0d", k), 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
         stepTo(24 * k + 3);
         checkBit($sformatf("toPulseHeld%0d", k), pll_rst, 1'b1);
         stepTo(24 * k + 4);
         checkOutput($sformatf("toPulseEnd%0d", k), 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      end
`endif

      // Repeated lock loss in RUN saturates relock_cnt at 255.
      $display("[TB] relock saturation");
      applyStimulus(1'b1);
      doReset();
      waitSys(1'b1, 50, ok);
      checkBit("firstRun", ok, 1'b1);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b0);
         waitSys(1'b0, 10, ok);
         checkBit("dropWait", ok, 1'b1);
         if (i == 0) begin
            checkOutput("firstRelock", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
         end
         applyStimulus(1'b1);
         waitSys(1'b1, 60, ok);
         checkBit("relockWait", ok, 1'b1);
      end
      checkOutput("relockSat", 1'b0, 1'b1, 1'b1, 8'd255, 1'b0);

      // rst_n asserted mid-cycle must act before the next clock edge.
      $display("[TB] async reset in RUN");
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
